// File: rtl/adc_scan_spi_if.sv
// Result stream of the ADC scanner: one conversion result and its channel tag,
// transferred with a valid/ready handshake.
interface adc_scan_spi_if #(
    parameter int CH_W   = 3,
    parameter int DATA_W = 12
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CH_W-1:0]   out_ch;

    modport master (output out_valid, output out_data, output out_ch, input out_ready);
    modport slave  (input out_valid, input out_data, input out_ch, output out_ready);
endinterface

// File: rtl/adc_scan_spi.sv
// Round-robin SPI scanner for a multi-channel serial ADC: streams address/data
// frames back to back while enabled and emits tagged results on a handshake port.
module adc_scan_spi #(
    parameter int NUM_CH = 8,
    parameter int CH_W   = 3,
    parameter int DATA_W = 12,
    parameter int LEAD   = 4,
    parameter int DIV    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              adc_dout,
    output logic              adc_din,
    output logic              adc_sclk,
    output logic              adc_cs_b,
    output logic              overrun,
    output logic              busy,
    adc_scan_spi_if.master    res
);
    localparam int FB    = LEAD + DATA_W;
    localparam int BIT_W = $clog2(FB);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q;
    logic              phase_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [CH_W-1:0]   addr_q;
    logic [CH_W-1:0]   tag_q;
    logic              first_q;
    logic [DATA_W-1:0] shift_q;
    logic              emit_q;
    logic              out_valid_q;
    logic              overrun_q;
    logic [DATA_W-1:0] out_data_q;
    logic [CH_W-1:0]   out_ch_q;

    logic              go;
    logic              phase_end;
    logic              bit_end;
    logic              frame_end;
    logic              frame_start;
    logic              in_addr_win;
    logic [CH_W-1:0]   din_pos;

    // Next set mask bit strictly after prev, wrapping; keeps prev if the mask is empty.
    function automatic logic [CH_W-1:0] next_set(input logic [NUM_CH-1:0] m,
                                                 input logic [CH_W-1:0]   prev);
        logic [CH_W-1:0] r;
        logic            found;
        int              idx;
        r     = prev;
        found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = (int'(prev) + i) % NUM_CH;
            if (!found && m[idx[CH_W-1:0]]) begin
                r     = idx[CH_W-1:0];
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign go          = enable && (ch_mask != '0);
    assign phase_end   = (div_cnt_q == DIV_W'(DIV - 1));
    assign bit_end     = (state_q == SHIFT) && phase_q && phase_end;
    assign frame_end   = bit_end && (bit_cnt_q == BIT_W'(FB - 1));
    assign frame_start = (state_q == SHIFT) && (bit_cnt_q == '0) && !phase_q && (div_cnt_q == '0);
    assign in_addr_win = (bit_cnt_q >= BIT_W'(2)) && (bit_cnt_q <= BIT_W'(CH_W + 1));
    assign din_pos     = CH_W'(CH_W + 1 - int'(bit_cnt_q));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = SETUP;
            SETUP:   if (phase_end) state_d = SHIFT;
            SHIFT:   if (frame_end && !go) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        adc_cs_b = 1'b1;
        adc_sclk = 1'b1;
        adc_din  = 1'b0;
        busy     = 1'b0;
        case (state_q)
            SETUP: begin
                adc_cs_b = 1'b0;
                busy     = 1'b1;
            end
            SHIFT: begin
                adc_cs_b = 1'b0;
                busy     = 1'b1;
                adc_sclk = phase_q;
                if (in_addr_win) adc_din = addr_q[din_pos];
            end
            default: ;
        endcase
    end

    // Bit timing: div_cnt_q paces each half period, phase_q=0 is the low half.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            phase_q   <= 1'b0;
            bit_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            div_cnt_q <= '0;
            phase_q   <= 1'b0;
            bit_cnt_q <= '0;
        end else begin
            div_cnt_q <= phase_end ? '0 : div_cnt_q + DIV_W'(1);
            if ((state_q == SHIFT) && phase_end) begin
                phase_q <= !phase_q;
                if (phase_q)
                    bit_cnt_q <= (bit_cnt_q == BIT_W'(FB - 1)) ? '0 : bit_cnt_q + BIT_W'(1);
            end
        end
    end

    // The tag of a frame is the address sent in the previous one; the first
    // frame after chip select falls converts channel 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_q <= 1'b0;
            addr_q  <= '0;
            tag_q   <= '0;
            shift_q <= '0;
            emit_q  <= 1'b0;
        end else begin
            if ((state_q == IDLE) && go) first_q <= 1'b1;
            if (frame_start) begin
                first_q <= 1'b0;
                tag_q   <= first_q ? '0 : addr_q;
                addr_q  <= next_set(ch_mask, first_q ? CH_W'(NUM_CH - 1) : addr_q);
            end
            if (bit_end) shift_q <= {shift_q[DATA_W-2:0], adc_dout};
            emit_q <= frame_end && ch_mask[tag_q];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            overrun_q   <= 1'b0;
        end else if (emit_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= shift_q;
            out_ch_q    <= tag_q;
            if (out_valid_q && !res.out_ready) overrun_q <= 1'b1;
        end else if (out_valid_q && res.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign res.out_valid = out_valid_q;
    assign res.out_data  = out_data_q;
    assign res.out_ch    = out_ch_q;
    assign overrun       = overrun_q;
endmodule

// File: tb/tb_adc_scan_spi.sv
// Bench for adc_scan_spi: behavioural serial ADC, expected-result queue with a
// handshake monitor, plus a DIV=3 instance for sclk/chip-select timing.
module tb_adc_scan_spi;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] ch_mask = 8'h00;
    logic       adc_dout = 1'b0;
    logic       adc_din, adc_sclk, adc_cs_b, overrun, busy;

    logic       enable2 = 1'b0;
    logic [7:0] mask2 = 8'h02;
    logic       dout2 = 1'b0;
    logic       din2, sclk2, cs2, ovr2, busy2;

    int total = 0;
    int bad   = 0;
    int pops  = 0;

    adc_scan_spi_if #(.CH_W(3), .DATA_W(12)) ifc ();
    adc_scan_spi_if #(.CH_W(3), .DATA_W(12)) ifc2 ();

    adc_scan_spi u_dut (
        .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask),
        .adc_dout(adc_dout), .adc_din(adc_din), .adc_sclk(adc_sclk), .adc_cs_b(adc_cs_b),
        .overrun(overrun), .busy(busy), .res(ifc)
    );

    adc_scan_spi #(.DIV(3)) u_dut2 (
        .clk(clk), .reset(reset), .enable(enable2), .ch_mask(mask2),
        .adc_dout(dout2), .adc_din(din2), .adc_sclk(sclk2), .adc_cs_b(cs2),
        .overrun(ovr2), .busy(busy2), .res(ifc2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] data;
        logic [2:0]  ch;
    } exp_t;
    exp_t q[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // ADC model: shifts out the word of the channel addressed in the previous frame
    int          mode = 0;
    int          k = -1;
    int          conv_ch = 0;
    int          din_err = 0;
    logic [2:0]  addr_acc = 3'd0;
    logic [11:0] cur_word = 12'd0;
    logic        cs_prev = 1'b1;
    logic        sclk_prev = 1'b1;

    function automatic logic [11:0] adc_val(input int ch);
        case (mode)
            0:       return 12'hA5C;
            1:       return 12'(ch * 'h111);
            default: return 12'(12'h5A0 + ch);
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        if (reset) begin
            k        = -1;
            conv_ch  = 0;
            adc_dout = 1'b0;
        end else begin
            if (cs_prev && !adc_cs_b) begin
                k       = -1;
                conv_ch = 0;
            end
            if (!cs_prev && adc_cs_b) check("frame_len_at_cs_rise", k, 15);
            if (!adc_cs_b) begin
                if (sclk_prev && !adc_sclk) begin
                    k++;
                    if (k == 16) begin
                        k       = 0;
                        conv_ch = int'(addr_acc);
                    end
                    if (k == 0) cur_word = adc_val(conv_ch);
                end
                if (!sclk_prev && adc_sclk && k >= 2 && k <= 4) addr_acc = {addr_acc[1:0], adc_din};
                if ((k < 2 || k > 4) && adc_din) din_err++;
                adc_dout = (k >= 4) ? cur_word[15-k] : 1'b0;
            end
        end
        cs_prev   = adc_cs_b;
        sclk_prev = adc_sclk;
    end

    // Monitor: every accepted result is matched against the expected queue.
    always @(negedge clk) begin
        if (ifc.out_valid && ifc.out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got data=0x%0h ch=%0d, required none",
                         ifc.out_data, ifc.out_ch);
            end else begin
                exp_t e;
                e = q.pop_front();
                $display("xfer data=0x%03h ch=%0d (expected 0x%03h ch=%0d)",
                         ifc.out_data, ifc.out_ch, e.data, e.ch);
                check("out_data", int'(ifc.out_data), int'(e.data));
                check("out_ch", int'(ifc.out_ch), int'(e.ch));
                pops++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_cs_high(input string name);
        int n = 0;
        while (!adc_cs_b && n < 2000) begin
            tick();
            n++;
        end
        check(name, int'(adc_cs_b), 1);
    endtask

    task automatic wait_pops(input string name, input int target);
        int n = 0;
        while (pops < target && n < 3000) begin
            tick();
            n++;
        end
        check(name, pops, target);
    endtask

    task automatic wait_k(input string name, input int val);
        int n = 0;
        while (k != val && n < 2000) begin
            tick();
            n++;
        end
        check(name, k, val);
    endtask

    task automatic push(input logic [11:0] d, input logic [2:0] c);
        exp_t e;
        e.data = d;
        e.ch   = c;
        q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int          base;
        int          cs_fall, first_low, low_len, high_len, nrises, stab_err;
        logic [2:0]  addr2;
        logic [119:0] s2, c2, d2;

        ifc.out_ready  = 1'b1;
        ifc2.out_ready = 1'b1;
        repeat (3) tick();
        check("rst_cs_b", int'(adc_cs_b), 1);
        check("rst_sclk", int'(adc_sclk), 1);
        check("rst_din", int'(adc_din), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(ifc.out_valid), 0);
        check("rst_data", int'(ifc.out_data), 0);
        check("rst_ch", int'(ifc.out_ch), 0);
        check("rst_overrun", int'(overrun), 0);
        reset = 1'b0;
        repeat (2) tick();

        // single frame from a one-cycle enable pulse
        mode = 0;
        ch_mask = 8'h01;
        push(12'hA5C, 3'd0);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        check("t1_busy", int'(busy), 1);
        wait_cs_high("t1_cs_rise");
        check("t1_valid_at_cs_rise", int'(ifc.out_valid), 0);
        tick();
        check("t1_valid_latency", int'(ifc.out_valid), 1);
        check("t1_data", int'(ifc.out_data), 'hA5C);
        repeat (3) tick();
        check("t1_cs_idle", int'(adc_cs_b), 1);
        check("t1_queue_empty", q.size(), 0);

        // round robin over channels 1 and 3, channel-0 frame dropped
        mode = 1;
        ch_mask = 8'h0A;
        push(12'h111, 3'd1);
        push(12'h333, 3'd3);
        push(12'h111, 3'd1);
        push(12'h333, 3'd3);
        base = pops;
        enable = 1'b1;
        wait_pops("t2_three_results", base + 3);
        enable = 1'b0;
        wait_cs_high("t2_cs_rise");
        repeat (3) tick();
        check("t2_queue_empty", q.size(), 0);

        // enable withdrawn at bit 5: frame still completes and emits
        mode = 0;
        ch_mask = 8'h01;
        push(12'hA5C, 3'd0);
        enable = 1'b1;
        wait_k("t3_reach_bit5", 5);
        enable = 1'b0;
        wait_cs_high("t3_cs_rise");
        repeat (3) tick();
        check("t3_queue_empty", q.size(), 0);

        // overrun: two results without ready
        mode = 1;
        ch_mask = 8'h06;
        ifc.out_ready = 1'b0;
        enable = 1'b1;
        begin
            int n = 0;
            while (!ifc.out_valid && n < 2000) begin
                tick();
                n++;
            end
        end
        check("t4_first_valid", int'(ifc.out_valid), 1);
        check("t4_no_overrun_yet", int'(overrun), 0);
        check("t4_first_data", int'(ifc.out_data), 'h111);
        check("t4_first_ch", int'(ifc.out_ch), 1);
        enable = 1'b0;
        push(12'h222, 3'd2);
        wait_cs_high("t4_cs_rise");
        repeat (3) tick();
        check("t4_valid_held", int'(ifc.out_valid), 1);
        check("t4_overrun_set", int'(overrun), 1);
        check("t4_second_data", int'(ifc.out_data), 'h222);
        check("t4_second_ch", int'(ifc.out_ch), 2);
        ifc.out_ready = 1'b1;
        repeat (2) tick();
        check("t4_valid_cleared", int'(ifc.out_valid), 0);
        check("t4_overrun_sticky", int'(overrun), 1);
        check("t4_queue_empty", q.size(), 0);

        // reset at bit 9 of a frame, then a fresh scan tagged channel 0
        mode = 2;
        ch_mask = 8'h06;
        push(12'h5A1, 3'd1);
        base = pops;
        enable = 1'b1;
        wait_pops("t5_pre_reset_result", base + 1);
        wait_k("t5_reach_bit9", 9);
        reset = 1'b1;
        #1;
        check("t5_rst_cs_b", int'(adc_cs_b), 1);
        check("t5_rst_sclk", int'(adc_sclk), 1);
        check("t5_rst_din", int'(adc_din), 0);
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_valid", int'(ifc.out_valid), 0);
        check("t5_rst_data", int'(ifc.out_data), 0);
        check("t5_rst_ch", int'(ifc.out_ch), 0);
        check("t5_rst_overrun", int'(overrun), 0);
        ch_mask = 8'h07;
        push(12'h5A0, 3'd0);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        enable = 1'b0;
        wait_cs_high("t5_cs_rise");
        repeat (3) tick();
        check("t5_queue_empty", q.size(), 0);

        // DIV=3 instance: setup gap, half periods, din stable over rising edges
        enable2 = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            #1;
            s2[i] = sclk2;
            c2[i] = cs2;
            d2[i] = din2;
            if (i == 0) enable2 = 1'b0;
            if (i == 10) check("t6_busy", int'(busy2), 1);
        end
        cs_fall = -1;
        first_low = -1;
        for (int i = 0; i < 120; i++) begin
            if (cs_fall < 0 && !c2[i]) cs_fall = i;
            if (first_low < 0 && !s2[i]) first_low = i;
        end
        check("t6_setup_gap", first_low - cs_fall, 3);
        low_len = 0;
        high_len = 0;
        for (int i = first_low; i >= 0 && i < 120 && !s2[i]; i++) low_len++;
        for (int i = first_low + low_len; i < 120 && s2[i]; i++) high_len++;
        check("t6_low_half", low_len, 3);
        check("t6_high_half", high_len, 3);
        nrises = 0;
        stab_err = 0;
        addr2 = 3'd0;
        for (int i = 1; i < 120; i++) begin
            if (!c2[i] && !s2[i-1] && s2[i]) begin
                if (d2[i-1] != d2[i]) stab_err++;
                if (nrises >= 2 && nrises <= 4) addr2 = {addr2[1:0], d2[i]};
                nrises++;
            end
        end
        check("t6_rising_edges", nrises, 16);
        check("t6_din_stable", stab_err, 0);
        check("t6_address", int'(addr2), 1);
        check("t6_cs_idle", int'(cs2), 1);
        check("t6_overrun", int'(ovr2), 0);

        check("din_zero_outside_addr", din_err, 0);
        check("final_queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adc_scan_spi.md
ADC_SCAN_SPI -- requirements
Module: adc_scan_spi

Interface
REQ-001 Parameter NUM_CH, default 8: number of ADC input channels; legal range 2..8.
REQ-002 Parameter CH_W, default 3: address width, equal to clog2(NUM_CH).
REQ-003 Parameter DATA_W, default 12: conversion result width.
REQ-004 Parameter LEAD, default 4: number of leading zero bits per frame; frame length FB = LEAD+DATA_W bits.
REQ-005 Parameter DIV, default 1: adc_sclk half-period in clk cycles; must be >= 1.
REQ-006 Port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-007 Port reset, input, width 1: asynchronous, active-high reset.
REQ-008 Port enable, input, width 1: scan request; level-sensitive.
REQ-009 Port ch_mask, input, width NUM_CH: channels to scan; bit i set means channel i is included.
REQ-010 Port adc_dout, input, width 1: serial data from the ADC.
REQ-011 Port adc_din, output, width 1: serial address to the ADC.
REQ-012 Port adc_sclk, output, width 1: serial clock; idles high.
REQ-013 Port adc_cs_b, output, width 1: active-low chip select.
REQ-014 Port out_valid, output, width 1: result is available.
REQ-015 Port out_ready, input, width 1: consumer accepts the result.
REQ-016 Port out_data, output, width DATA_W: conversion result.
REQ-017 Port out_ch, output, width CH_W: channel that produced out_data.
REQ-018 Port overrun, output, width 1: sticky flag; an unaccepted result was overwritten.
REQ-019 Port busy, output, width 1: high whenever adc_cs_b is low.

Function
REQ-020 The FSM SHALL have three states: IDLE, SETUP and SHIFT.
- IDLE -> SETUP when enable=1 and ch_mask!=0.
- SETUP lasts DIV cycles with adc_cs_b=0 and adc_sclk=1, then goes to SHIFT.
REQ-021 In SHIFT, each frame bit k (0..FB-1) SHALL consist of:
- adc_sclk low for DIV cycles, with adc_din updated on the falling edge;
- then adc_sclk high for DIV cycles, with adc_dout sampled on the last clk of the high phase.
REQ-022 adc_din SHALL carry address bit CH_W-1-(k-2) for k in 2..2+CH_W-1, MSB first, and 0 for all other k.
REQ-023 Samples at k < LEAD SHALL be discarded; samples at k >= LEAD SHALL fill the result MSB first.
REQ-024 After bit FB-1, the SHIFT FSM SHALL:
- if enable=1 and ch_mask!=0, start the next frame on the next clk with adc_cs_b held low and no SETUP;
- otherwise, raise adc_cs_b and go to IDLE.
REQ-025 The address sent in frame N SHALL select the channel converted in frame N+1.
REQ-026 The first frame after adc_cs_b falls SHALL be tagged as channel 0.
REQ-027 The address sent in each frame SHALL be the next set ch_mask bit after the previous address, searching upward with wrap-around.
REQ-028 The first frame's address SHALL be the lowest set bit of ch_mask.
REQ-029 ch_mask SHALL be sampled once per frame, at bit 0.
REQ-030 A frame result SHALL be emitted only if its tag bit is set in ch_mask at frame end; otherwise it is dropped silently.
REQ-031 An emitted result SHALL load out_data and out_ch and set out_valid one clk after the final sample (latency 1).
REQ-032 out_valid SHALL clear on the clk where out_valid=1 and out_ready=1, unless a new result loads on that same clk, in which case out_valid stays 1 with the new data and overrun is not set.
REQ-033 A new result arriving while out_valid=1 and out_ready=0 SHALL overwrite out_data and out_ch and set overrun.
REQ-034 overrun SHALL be cleared only by reset.
REQ-035 If enable falls mid-frame, the current frame SHALL complete and its result SHALL be emitted under REQ-030.
REQ-036 If ch_mask becomes 0 mid-frame, the current frame SHALL complete, then the FSM goes to IDLE.

Reset
REQ-037 Asserting reset SHALL immediately force:
- state=IDLE, adc_cs_b=1, adc_sclk=1, adc_din=0;
- out_valid=0, out_data=0, out_ch=0, overrun=0, busy=0;
- all counters to 0.
REQ-038 Reset mid-frame SHALL abort the frame with no result emitted.
REQ-039 After reset deasserts, the next frame SHALL be tagged channel 0 per REQ-026.

Verification
REQ-040 DIV=1, ch_mask=0x01, enable pulse of 1 cycle, ADC model returns 0xA5C -> one 16-bit frame with adc_din all 0; out_data=0xA5C and out_ch=0 one clk after the last sample; adc_cs_b high afterwards.
REQ-041 ch_mask=0x0A, enable held, ADC returns channel number times 0x111 -> addresses 1,3,1,3,...; the frame-0 ch0 result is dropped; outputs 0x111/ch1, 0x333/ch3, 0x111/ch1 in order.
REQ-042 DIV=3 -> adc_sclk half-period measures 3 clk; the SETUP gap is 3 clk; the adc_din address bits are stable across each rising edge.
REQ-043 out_ready=0 across two emitted results -> overrun=1 and out_data equals the second result; then out_ready=1 -> out_valid clears and overrun stays 1.
REQ-044 Reset asserted at bit 9 of a frame -> adc_cs_b=1 and adc_sclk=1 in the same cycle, with no out_valid; after reset, the first frame is tagged ch0.
REQ-045 enable dropped at bit 5 -> the frame completes, its result is emitted, and adc_cs_b rises after bit 15.
